reservoir_ctrl_param: RTL and testbench
=======================================

Name: reservoir_ctrl_param

Overview:
Parametrised next-generation reservoir controller. It integrates rain inflow into a stored water level and releases water through a turbine according to a three-mode FSM (NORMAL / FLOOD / DROUGHT) with hysteresis and minimum dwell time. It reports per-cycle generated electricity, a saturating energy total, and a spill indication. It replaces the fixed 8-bit reservoir top as the core of the reservoir subsystem.

Parameters:
W, 8, data width of rain, demand, level, release, electric
CAP, 200, reservoir capacity; level clamps here (must be <= 2^W-1)
INIT_LEVEL, 100, level loaded on reset
HIGH, 150, flood entry threshold (level >= HIGH)
LOW, 40, drought entry threshold (level <= LOW)
HYST, 10, exit hysteresis; constraint LOW+HYST < HIGH-HYST
BASE_OUT, 10, maximum release per cycle in NORMAL
FLOOD_OUT, 30, forced release per cycle in FLOOD
GEN_SHIFT, 1, electric = release >> GEN_SHIFT
MIN_DWELL, 4, cycles in a state before an entry transition out of NORMAL is allowed

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
rain_valid  in  1  rain sample valid this cycle
rain  in  W  inflow amount; ignored when rain_valid=0
demand  in  W  requested release in NORMAL
out  out  W  water released on the last edge
now  out  W  current water level
electric  out  W  energy generated on the last edge
energy_total  out  2W  saturating sum of electric
mode  out  2  0=NORMAL, 1=FLOOD, 2=DROUGHT
spill  out  1  high for one cycle when the level clamped at CAP
spill_amt  out  W  excess discarded on that edge; 0 otherwise

Behaviour:
- Reset is synchronous. On any edge with rst=1: now=INIT_LEVEL, out=0, electric=0, energy_total=0, mode=NORMAL, dwell=0, spill=0, spill_amt=0. Reset overrides everything, mid-operation included.
- All outputs are registered. Every per-edge computation uses the registered now and mode.
- Requested release req: NORMAL gives min(demand, BASE_OUT). FLOOD gives FLOOD_OUT. DROUGHT gives 0.
- rel = min(req, now), so the level never underflows.
- inflow = rain_valid ? rain : 0.
- sum = now - rel + inflow, computed in W+1 bits.
- If sum > CAP: now<=CAP, spill<=1, spill_amt<=sum-CAP. Otherwise: now<=sum, spill<=0, spill_amt<=0.
- out<=rel and electric<=rel>>GEN_SHIFT on the same edge.
- energy_total <= energy_total + (rel>>GEN_SHIFT), saturating at all-ones (2W bits). It does not wrap.
- Latency: rain sampled at edge t is visible in now after edge t. The mode change caused by that level takes effect at edge t+1. The new mode's release applies from edge t+2.
- FSM transitions are evaluated on the registered now and dwell:
  - NORMAL->FLOOD if now >= HIGH and dwell >= MIN_DWELL.
  - NORMAL->DROUGHT if now <= LOW and dwell >= MIN_DWELL. The FLOOD check has priority.
  - FLOOD->NORMAL if now < HIGH-HYST. No dwell requirement.
  - DROUGHT->NORMAL if now > LOW+HYST. No dwell requirement.
  - Codes 3 (illegal) go to NORMAL with dwell=0.
- dwell counter: cleared on every mode change and on reset; otherwise increments, saturating at MIN_DWELL.
- Simultaneous events: a mode transition and a level update on the same edge both occur. The level update uses the old mode's release.

Test Plan:
- Reset: hold rst=1 for 2 cycles with rain=50 valid -> now=100, out=0, electric=0, energy_total=0, mode=0, spill=0.
- Steady NORMAL: rain=10 valid, demand=25 for 5 cycles -> out=10 (capped), electric=5, now stays 100, energy_total=25.
- Flood entry/exit: after reset, run 4 idle cycles (demand=0, no rain), then one cycle of rain=60, then no rain. Required response:
  - now=160, then mode=1 with now=160.
  - Next edge: out=30, electric=15, now=130.
  - Next edge: mode=0, now=100.
- Spill: from reset level 100, demand=0, one cycle of rain=120 -> now=200, spill=1, spill_amt=20. The next cycle with no rain gives spill=0, spill_amt=0.
- Drought: from 100 with demand=10, no rain, dwell satisfied. Required response:
  - now decreases by 10 per edge.
  - The edge after now=40 sets mode=2; now=30 on that edge (NORMAL release still applied).
  - Then out=0.
  - One cycle of rain=25 gives now=55, then mode=0.
- Reset mid-FLOOD: assert rst for one cycle while mode=1, energy_total>0 -> all outputs take their reset values on that edge. Normal operation resumes the next cycle.

Source files
------------

// File: rtl/reservoir_ctrl_param.sv
// Parametrised reservoir controller: integrates rain into a stored level, releases water
// through a turbine under a NORMAL/FLOOD/DROUGHT mode FSM with hysteresis and dwell time.
module reservoir_ctrl_param #(
  parameter int unsigned W          = 8,
  parameter int unsigned CAP        = 200,
  parameter int unsigned INIT_LEVEL = 100,
  parameter int unsigned HIGH       = 150,
  parameter int unsigned LOW        = 40,
  parameter int unsigned HYST       = 10,
  parameter int unsigned BASE_OUT   = 10,
  parameter int unsigned FLOOD_OUT  = 30,
  parameter int unsigned GEN_SHIFT  = 1,
  parameter int unsigned MIN_DWELL  = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rain_valid,
  input  logic [W-1:0]   rain,
  input  logic [W-1:0]   demand,
  output logic [W-1:0]   out,
  output logic [W-1:0]   now,
  output logic [W-1:0]   electric,
  output logic [2*W-1:0] energy_total,
  output logic [1:0]     mode,
  output logic           spill,
  output logic [W-1:0]   spill_amt
);

  localparam logic [1:0] ModeNormal  = 2'd0;
  localparam logic [1:0] ModeFlood   = 2'd1;
  localparam logic [1:0] ModeDrought = 2'd2;

  localparam int unsigned DW = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);

  localparam logic [W-1:0]  InitLevel   = W'(INIT_LEVEL);
  localparam logic [W-1:0]  CapLevel    = W'(CAP);
  localparam logic [W:0]    CapWide     = (W+1)'(CAP);
  localparam logic [W-1:0]  High        = W'(HIGH);
  localparam logic [W-1:0]  Low         = W'(LOW);
  localparam logic [W-1:0]  FloodExit   = W'(HIGH - HYST);
  localparam logic [W-1:0]  DroughtExit = W'(LOW + HYST);
  localparam logic [W-1:0]  BaseOut     = W'(BASE_OUT);
  localparam logic [W-1:0]  FloodOut    = W'(FLOOD_OUT);
  localparam logic [DW-1:0] MinDwell    = DW'(MIN_DWELL);

  logic [DW-1:0] dwell;
  logic [W-1:0]  req;
  logic [W-1:0]  rel;
  logic [W-1:0]  inflow;
  logic [W-1:0]  gen;
  logic [W:0]    sum;
  logic [2*W:0]  energy_sum;
  logic [1:0]    mode_next;

  always_comb begin
    req = '0;
    case (mode)
      ModeNormal: req = (demand < BaseOut) ? demand : BaseOut;
      ModeFlood:  req = FloodOut;
      default:    req = '0;
    endcase
    // Never release more than is stored, so the level cannot underflow.
    rel        = (req < now) ? req : now;
    inflow     = rain_valid ? rain : '0;
    sum        = {1'b0, now} - {1'b0, rel} + {1'b0, inflow};
    gen        = rel >> GEN_SHIFT;
    energy_sum = {1'b0, energy_total} + {{(W+1){1'b0}}, gen};
  end

  always_comb begin
    mode_next = mode;
    case (mode)
      ModeNormal: begin
        if (now >= High && dwell >= MinDwell) begin
          mode_next = ModeFlood;
        end else if (now <= Low && dwell >= MinDwell) begin
          mode_next = ModeDrought;
        end
      end
      ModeFlood: begin
        if (now < FloodExit) mode_next = ModeNormal;
      end
      ModeDrought: begin
        if (now > DroughtExit) mode_next = ModeNormal;
      end
      default: mode_next = ModeNormal;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      now          <= InitLevel;
      out          <= '0;
      electric     <= '0;
      energy_total <= '0;
      mode         <= ModeNormal;
      dwell        <= '0;
      spill        <= 1'b0;
      spill_amt    <= '0;
    end else begin
      mode <= mode_next;
      if (mode_next != mode) begin
        dwell <= '0;
      end else if (dwell < MinDwell) begin
        dwell <= dwell + DW'(1);
      end
      out          <= rel;
      electric     <= gen;
      energy_total <= energy_sum[2*W] ? '1 : energy_sum[2*W-1:0];
      if (sum > CapWide) begin
        now       <= CapLevel;
        spill     <= 1'b1;
        spill_amt <= W'(sum - CapWide);
      end else begin
        now       <= sum[W-1:0];
        spill     <= 1'b0;
        spill_amt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reservoir_ctrl_param.sv
// Scoreboard bench for reservoir_ctrl_param: directed steps push hand-computed expectations,
// a monitor pops one entry per clock edge and compares every output.
module tb_reservoir_ctrl_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rain_valid = 1'b0;
  logic [W-1:0]   rain = '0;
  logic [W-1:0]   demand = '0;
  logic [W-1:0]   out;
  logic [W-1:0]   now;
  logic [W-1:0]   electric;
  logic [2*W-1:0] energy_total;
  logic [1:0]     mode;
  logic           spill;
  logic [W-1:0]   spill_amt;

  reservoir_ctrl_param dut (
    .clk          (clk),
    .rst          (rst),
    .rain_valid   (rain_valid),
    .rain         (rain),
    .demand       (demand),
    .out          (out),
    .now          (now),
    .electric     (electric),
    .energy_total (energy_total),
    .mode         (mode),
    .spill        (spill),
    .spill_amt    (spill_amt)
  );

  always #5 clk = ~clk;

  // A field of -1 means "not checked on this edge".
  typedef struct {
    int lvl;
    int rel;
    int el;
    int en;
    int md;
    int sp;
    int samt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   edge_no = 0;

  task automatic chk(input string name, input int act, input int expv);
    if (expv >= 0) begin
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s edge %0d: got %0d, expected %0d", name, edge_no, act, expv);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    edge_no++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("now",          int'(now),          e.lvl);
      chk("out",          int'(out),          e.rel);
      chk("electric",     int'(electric),     e.el);
      chk("energy_total", int'(energy_total), e.en);
      chk("mode",         int'(mode),         e.md);
      chk("spill",        int'(spill),        e.sp);
      chk("spill_amt",    int'(spill_amt),    e.samt);
    end
  end

  task automatic step(input logic r, input logic v, input int rn, input int dm,
                      input int e_now, input int e_out, input int e_el, input int e_en,
                      input int e_mode, input int e_sp, input int e_samt);
    exp_t e;
    @(negedge clk);
    rst        = r;
    rain_valid = v;
    rain       = W'(rn);
    demand     = W'(dm);
    e.lvl = e_now; e.rel = e_out; e.el = e_el; e.en = e_en;
    e.md = e_mode; e.sp = e_sp; e.samt = e_samt;
    q.push_back(e);
    @(posedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 100, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input int e_now, input int e_out, input int e_en, input int e_mode);
    step(0, 0, 0, 0, e_now, e_out, e_out / 2, e_en, e_mode, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int en;

    // Reset held two cycles while rain is offered.
    step(1, 1, 50, 0, 100, 0, 0, 0, 0, 0, 0);
    step(1, 1, 50, 0, 100, 0, 0, 0, 0, 0, 0);

    // Steady NORMAL: demand capped at BASE_OUT, inflow balances release.
    for (int k = 1; k <= 5; k++) step(0, 1, 10, 25, 100, 10, 5, 5 * k, 0, 0, 0);

    // Flood entry and exit.
    do_reset();
    for (int k = 0; k < 4; k++) idle(100, 0, 0, 0);
    step(0, 1, 60, 0, 160, 0, 0, 0, 0, 0, 0);
    idle(160, 0, 0, 1);
    idle(130, 30, 15, 1);
    idle(100, 30, 30, 0);

    // Reset while in FLOOD with energy accumulated, then resume.
    do_reset();
    for (int k = 0; k < 4; k++) idle(100, 0, 0, 0);
    step(0, 1, 60, 0, 160, 0, 0, 0, 0, 0, 0);
    idle(160, 0, 0, 1);
    idle(130, 30, 15, 1);
    do_reset();
    idle(100, 0, 0, 0);
    step(0, 0, 0, 10, 90, 10, 5, 5, 0, 0, 0);

    // Spill, exact-capacity boundary, and largest overflow.
    do_reset();
    step(0, 1, 120, 0, 200, 0, 0, 0, 0, 1, 20);
    idle(200, 0, 0, 0);
    step(0, 1, 10, 10, 200, 10, 5, 5, 0, 0, 0);
    step(0, 1, 255, 0, 200, 0, 0, 5, 0, 1, 255);

    // Drought entry at LOW, zero release, exit after rain.
    do_reset();
    for (int k = 1; k <= 6; k++) step(0, 0, 0, 10, 100 - 10 * k, 10, 5, 5 * k, 0, 0, 0);
    step(0, 0, 0, 10, 30, 10, 5, 35, 2, 0, 0);
    step(0, 0, 0, 10, 30, 0, 0, 35, 2, 0, 0);
    step(0, 1, 25, 10, 55, 0, 0, 35, 2, 0, 0);
    step(0, 0, 0, 10, 55, 0, 0, 35, 0, 0, 0);
    step(0, 0, 0, 10, 45, 10, 5, 40, 0, 0, 0);

    // Energy total saturates at all-ones instead of wrapping.
    do_reset();
    for (int k = 0; k < 4; k++) idle(100, 0, 0, 0);
    step(0, 1, 60, 0, 160, 0, 0, 0, 0, 0, 0);
    idle(160, 0, 0, 1);
    for (int k = 1; k <= 4375; k++) begin
      en = (15 * k > 65535) ? 65535 : 15 * k;
      step(0, 1, 30, 0, 160, 30, 15, en, 1, 0, 0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
